// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: processes SLICE bits per clock through a ripple
// chain, carrying between slices in a register. Signed overflow is taken from the top slice.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;

  logic [SLICE-1:0] a_slice;
  logic [SLICE-1:0] b_slice;
  logic [SLICE-1:0] sum_slice;
  logic [SLICE:0]   c;
  logic             last_slice;

  assign a_slice    = a_reg[cnt_reg*SLICE +: SLICE];
  assign b_slice    = b_reg[cnt_reg*SLICE +: SLICE];
  assign last_slice = (cnt_reg == CW'(NSLICE - 1));
  assign c[0]       = carry_reg;

  // Explicit ripple so the carry into the MSB (c[SLICE-1]) is available for overflow.
  generate
    for (genvar gi = 0; gi < SLICE; gi++) begin : g_ripple
      assign sum_slice[gi] = a_slice[gi] ^ b_slice[gi] ^ c[gi];
      assign c[gi+1]       = (a_slice[gi] & b_slice[gi]) | (c[gi] & (a_slice[gi] ^ b_slice[gi]));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b ^ {WIDTH{sub}};
            carry_reg <= sub ? 1'b1 : cin;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          s[cnt_reg*SLICE +: SLICE] <= sum_slice;
          carry_reg                 <= c[SLICE];
          if (last_slice) begin
            cout      <= c[SLICE];
            ovf       <= c[SLICE] ^ c[SLICE-1];
            cnt_reg   <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_adder.sv
// Directed bench for seq_adder (WIDTH=16, SLICE=4): vector table plus
// hand-written sequences for ignored start, back-to-back and mid-run reset.
module tb_seq_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  int cyc = 0;
  int busy_total = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[9];

  seq_adder #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
    .s(s), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (busy) busy_total <= busy_total + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input vec_t v);
    sub = v.sub; a = v.a; b = v.b; cin = v.cin;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Called just after the accepting edge; checks latency, busy span, result and hold.
  task automatic finish_op(input vec_t v, input string tag, input int t0, input int b0);
    logic [W-1:0] s_done;
    wait_done();
    check({tag, "_latency"}, 32'(cyc - t0), 32'd4);
    check({tag, "_busy_cycles"}, 32'(busy_total - b0), 32'd4);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_s"}, {16'd0, s}, {16'd0, v.s});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, v.cout});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    s_done = s;
    $display("[TB] %s: sub=%b a=%h b=%h cin=%b -> s=%h cout=%b ovf=%b",
             tag, v.sub, v.a, v.b, v.cin, s, cout, ovf);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_s_hold"}, {16'd0, s}, {16'd0, s_done});
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int t0, b0;
    @(negedge clk);
    set_inputs(v);
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; b0 = busy_total;
    start = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    finish_op(v, tag, t0, b0);
  endtask

  initial begin
    vec_t v1, v2;
    int t0, b0, t1;

    vecs[0] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'h0001, 16'h0002, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h0010, 16'h0001, 1'b1, 16'h000F, 1'b1, 1'b0};

    // Reset state, with start held high to show it is ignored under reset.
    start = 1'b1; a = 16'h1111; b = 16'h2222;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    // First start accepted on the first edge after reset release.
    @(negedge clk);
    rst = 1'b0;
    set_inputs(vecs[0]);
    @(posedge clk); #1;
    t0 = cyc; b0 = busy_total;
    start = 1'b0;
    check("first_busy_rise", {31'd0, busy}, 32'd1);
    finish_op(vecs[0], "first", t0, b0);

    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // New operands and start pulsed during RUN must be ignored.
    v1 = '{1'b0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0};
    @(negedge clk);
    set_inputs(v1);
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc; b0 = busy_total;
    start = 1'b0;
    @(negedge clk);
    sub = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(v1, "ignore_start", t0, b0);

    // Back-to-back: start held through the DONE cycle.
    v1 = '{1'b0, 16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    v2 = '{1'b1, 16'h0003, 16'h0007, 1'b0, 16'hFFFC, 1'b0, 1'b0};
    @(negedge clk);
    set_inputs(v1);
    start = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    set_inputs(v2);
    wait_done();
    t1 = cyc;
    check("b2b_first_latency", 32'(t1 - t0), 32'd4);
    check("b2b_first_done", {31'd0, done}, 32'd1);
    check("b2b_first_s", {16'd0, s}, {16'd0, v1.s});
    $display("[TB] b2b_first: a=%h b=%h -> s=%h cout=%b ovf=%b", v1.a, v1.b, s, cout, ovf);
    @(posedge clk); #1;
    t0 = cyc; b0 = busy_total;
    start = 1'b0;
    check("b2b_rerun_busy", {31'd0, busy}, 32'd1);
    check("b2b_rerun_done", {31'd0, done}, 32'd0);
    wait_done();
    check("b2b_gap", 32'(cyc - t1 - 1), 32'd4);
    check("b2b_second_latency", 32'(cyc - t0), 32'd4);
    check("b2b_second_s", {16'd0, s}, {16'd0, v2.s});
    check("b2b_second_cout", {31'd0, cout}, {31'd0, v2.cout});
    check("b2b_second_ovf", {31'd0, ovf}, {31'd0, v2.ovf});
    $display("[TB] b2b_second: sub=1 a=%h b=%h -> s=%h cout=%b ovf=%b", v2.a, v2.b, s, cout, ovf);
    @(posedge clk); #1;

    // Asynchronous reset in the second RUN cycle, after an op left cout=ovf=1.
    run_op(vecs[3], "pre_rst");
    v1 = '{1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0};
    @(negedge clk);
    set_inputs(v1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    start = 1'b1;
    #1;
    check("midrst_s", {16'd0, s}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    check("midrst_ovf", {31'd0, ovf}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_done", {31'd0, done}, 32'd0);
    check("midrst_still_idle", {31'd0, busy}, 32'd0);
    $display("[TB] midrst: reset asserted during RUN, s=%h busy=%b done=%b", s, busy, done);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    run_op(v1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
